// File: rtl/clk_div_pkg.sv
// Shared types for the clk_div_ctrl clock-enable scheduler: channel states and config word.
package clk_div_pkg;

   localparam int CNT_W_DEF = 32;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      PEND
   } chan_state_t;

   typedef struct packed {
      logic [CNT_W_DEF-1:0] div;
      logic                 en;
   } cfg_t;

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: FSM, counter, shadow config, registered tick and clk_out.
// Optional tick counter output when CLK_DIV_TICK_CNT_EN is defined.
module clk_div_chan
   import clk_div_pkg::*;
#(
   parameter int CNT_W       = CNT_W_DEF,
   parameter int DEFAULT_DIV = 2
) (
   input  logic        clk_in,
   input  logic        rst,
   input  logic        load_i,
   input  cfg_t        cfg_i,
   output logic        tick_o,
   output logic        clkOut_o,
   output logic        busy_o,
   output logic        pendNext_o
`ifdef CLK_DIV_TICK_CNT_EN
   ,
   output logic [15:0] tickCnt_o
`endif
);

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   chan_state_t      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] div_q, div_d;
   cfg_t             shadow_q, shadow_d;
   logic             tick_q, tick_d;
   logic             clk_q, clk_d;
   logic             terminal;

   assign terminal = (cnt_q == div_q - ONE);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      div_d    = div_q;
      shadow_d = shadow_q;
      tick_d   = 1'b0;
      clk_d    = clk_q;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            clk_d = 1'b0;
            if (load_i && cfg_i.en) begin
               div_d   = cfg_i.div[CNT_W-1:0];
               state_d = RUN;
            end
         end
         RUN, PEND: begin
            cnt_d = terminal ? '0 : cnt_q + ONE;
            if (terminal) begin
               tick_d = 1'b1;
               clk_d  = ~clk_q;
            end
            // A stop only lands on the tick that drops clk_out, so no high phase is cut short
            if (state_q == RUN) begin
               if (load_i) begin
                  shadow_d = cfg_i;
                  state_d  = PEND;
               end
            end else if (terminal) begin
               if (shadow_q.en) begin
                  div_d   = shadow_q.div[CNT_W-1:0];
                  state_d = RUN;
               end else if (clk_q) begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         div_q    <= CNT_W'(DEFAULT_DIV);
         shadow_q <= '0;
         tick_q   <= 1'b0;
         clk_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         div_q    <= div_d;
         shadow_q <= shadow_d;
         tick_q   <= tick_d;
         clk_q    <= clk_d;
      end
   end

   assign tick_o     = tick_q;
   assign clkOut_o   = clk_q;
   assign busy_o     = (state_q != IDLE);
   assign pendNext_o = (state_d == PEND);

`ifdef CLK_DIV_TICK_CNT_EN
   logic [15:0] tickCnt_q;

   always_ff @(posedge clk_in) begin
      if (rst) begin
         tickCnt_q <= '0;
      end else if (load_i && (state_q != IDLE || cfg_i.en)) begin
         tickCnt_q <= '0;
      end else if (tick_d) begin
         tickCnt_q <= tickCnt_q + 16'd1;
      end
   end

   assign tickCnt_o = tickCnt_q;
`endif

endmodule

// File: rtl/clk_div_ctrl.sv
// Multi-channel clock-enable scheduler: config handshake, channel decode and sticky error.
// Defining CLK_DIV_TICK_CNT_EN adds the per-channel tick_cnt output.
module clk_div_ctrl
   import clk_div_pkg::*;
#(
   parameter int NUM_CH      = 2,
   parameter int CNT_W       = CNT_W_DEF,
   parameter int DEFAULT_DIV = 2
) (
   input  logic                    clk_in,
   input  logic                    rst,
   input  logic                    cfg_valid,
   output logic                    cfg_ready,
   input  logic [2:0]              cfg_ch,
   input  logic [CNT_W-1:0]        cfg_div,
   input  logic                    cfg_en,
   output logic [NUM_CH-1:0]       tick,
   output logic [NUM_CH-1:0]       clk_out,
   output logic [NUM_CH-1:0]       busy,
   output logic                    cfg_err
`ifdef CLK_DIV_TICK_CNT_EN
   ,
   output logic [NUM_CH-1:0][15:0] tick_cnt
`endif
);

   logic              accept;
   logic              chValid;
   logic              divZero;
   logic [NUM_CH-1:0] pendNext;
   logic              cfgReady_q;
   logic              cfgErr_q;
   cfg_t              cfgWord;

   assign accept       = cfg_valid && cfgReady_q;
   assign chValid      = (int'(cfg_ch) < NUM_CH);
   assign divZero      = (cfg_div == '0);
   assign cfgWord.div  = divZero ? CNT_W_DEF'(1) : CNT_W_DEF'(cfg_div);
   assign cfgWord.en   = cfg_en;

   for (genvar g = 0; g < NUM_CH; g++) begin : gen_ch
      logic load;
      assign load = accept && chValid && (cfg_ch == 3'(g));

      clk_div_chan #(
         .CNT_W      (CNT_W),
         .DEFAULT_DIV(DEFAULT_DIV)
      ) u_chan (
         .clk_in    (clk_in),
         .rst       (rst),
         .load_i    (load),
         .cfg_i     (cfgWord),
         .tick_o    (tick[g]),
         .clkOut_o  (clk_out[g]),
         .busy_o    (busy[g]),
         .pendNext_o(pendNext[g])
`ifdef CLK_DIV_TICK_CNT_EN
         ,
         .tickCnt_o (tick_cnt[g])
`endif
      );
   end

   // Ready is built from next-state so it is already low in the first PEND cycle
   always_ff @(posedge clk_in) begin
      if (rst) begin
         cfgReady_q <= 1'b0;
         cfgErr_q   <= 1'b0;
      end else begin
         cfgReady_q <= ~|pendNext;
         if (accept && (divZero || !chValid)) begin
            cfgErr_q <= 1'b1;
         end
      end
   end

   assign cfg_ready = cfgReady_q;
   assign cfg_err   = cfgErr_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl: a cycle-by-cycle vector table plus hand sequences
// for stop, error, terminal-count collision and reset-during-PEND corner cases.
module tb_clk_div_ctrl;

   logic        clk_in;
   logic        rst;
   logic        cfg_valid;
   logic        cfg_ready;
   logic [2:0]  cfg_ch;
   logic [31:0] cfg_div;
   logic        cfg_en;
   logic [1:0]  tick;
   logic [1:0]  clk_out;
   logic [1:0]  busy;
   logic        cfg_err;
`ifdef CLK_DIV_TICK_CNT_EN
   logic [1:0][15:0] tick_cnt;
`endif

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        rst;
      logic        valid;
      logic [2:0]  ch;
      logic [31:0] div;
      logic        en;
      logic [1:0]  expTick;
      logic [1:0]  expClk;
      logic [1:0]  expBusy;
      logic        expReady;
      logic        expErr;
   } vec_t;

   vec_t vecs[$];

   clk_div_ctrl #(
      .NUM_CH     (2),
      .CNT_W      (32),
      .DEFAULT_DIV(2)
   ) dut (
      .clk_in   (clk_in),
      .rst      (rst),
      .cfg_valid(cfg_valid),
      .cfg_ready(cfg_ready),
      .cfg_ch   (cfg_ch),
      .cfg_div  (cfg_div),
      .cfg_en   (cfg_en),
      .tick     (tick),
      .clk_out  (clk_out),
      .busy     (busy),
      .cfg_err  (cfg_err)
`ifdef CLK_DIV_TICK_CNT_EN
      ,
      .tick_cnt (tick_cnt)
`endif
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   function automatic vec_t mk(logic r, logic v, logic [2:0] ch, logic [31:0] dv, logic en,
                               logic [1:0] t, logic [1:0] c, logic [1:0] b, logic rdy, logic er);
      vec_t x;
      x.rst = r; x.valid = v; x.ch = ch; x.div = dv; x.en = en;
      x.expTick = t; x.expClk = c; x.expBusy = b; x.expReady = rdy; x.expErr = er;
      return x;
   endfunction

   // Drive one cycle of inputs, then sample just after the rising edge that consumes them
   task automatic applyStimulus(input logic r, input logic v, input logic [2:0] ch,
                                input logic [31:0] dv, input logic en);
      rst       = r;
      cfg_valid = v;
      cfg_ch    = ch;
      cfg_div   = dv;
      cfg_en    = en;
      @(posedge clk_in);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic expectAll(input string tag, input logic [1:0] t, input logic [1:0] c,
                            input logic [1:0] b, input logic rdy, input logic er);
      checkOutput({tag, ".tick"}, 32'(tick), 32'(t));
      checkOutput({tag, ".clk_out"}, 32'(clk_out), 32'(c));
      checkOutput({tag, ".busy"}, 32'(busy), 32'(b));
      checkOutput({tag, ".cfg_ready"}, 32'(cfg_ready), 32'(rdy));
      checkOutput({tag, ".cfg_err"}, 32'(cfg_err), 32'(er));
   endtask

   task automatic idle(input string tag, input logic [1:0] t, input logic [1:0] c,
                       input logic [1:0] b, input logic rdy, input logic er);
      applyStimulus(1'b0, 1'b0, 3'd0, 32'd0, 1'b0);
      expectAll(tag, t, c, b, rdy, er);
   endtask

   initial begin
      rst = 1'b1; cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_en = 1'b0;

      // reset, ch0 div=4, mid-count switch to div=2, then ch1 div=1 alongside
      vecs.push_back(mk(1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 0));
      vecs.push_back(mk(0, 1, 0, 4, 1, 2'b00, 2'b00, 2'b01, 1, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01, 1, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01, 1, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01, 1, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b01, 1, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 1, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 1, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 1, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b01, 1, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01, 1, 0));
      vecs.push_back(mk(0, 1, 0, 2, 1, 2'b00, 2'b00, 2'b01, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b01, 1, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 1, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b01, 1, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01, 1, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b01, 1, 0));
      vecs.push_back(mk(0, 1, 1, 1, 1, 2'b00, 2'b01, 2'b11, 1, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 2'b11, 2'b10, 2'b11, 1, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b11, 1, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 2'b11, 2'b11, 2'b11, 1, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b11, 1, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 2'b11, 2'b10, 2'b11, 1, 0));
      vecs.push_back(mk(1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 0));

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].rst, vecs[i].valid, vecs[i].ch, vecs[i].div, vecs[i].en);
         expectAll($sformatf("vec%0d", i), vecs[i].expTick, vecs[i].expClk,
                   vecs[i].expBusy, vecs[i].expReady, vecs[i].expErr);
      end

      // ch0 div=3, stop requested while clk_out is low: full high phase, then idle
      applyStimulus(1'b0, 1'b1, 3'd0, 32'd3, 1'b1);
      expectAll("stop.acc", 2'b00, 2'b00, 2'b01, 1, 0);
      idle("stop.c1", 2'b00, 2'b00, 2'b01, 1, 0);
      idle("stop.c2", 2'b00, 2'b00, 2'b01, 1, 0);
      idle("stop.c3", 2'b01, 2'b01, 2'b01, 1, 0);
      idle("stop.c4", 2'b00, 2'b01, 2'b01, 1, 0);
      idle("stop.c5", 2'b00, 2'b01, 2'b01, 1, 0);
      idle("stop.c6", 2'b01, 2'b00, 2'b01, 1, 0);
      applyStimulus(1'b0, 1'b1, 3'd0, 32'd3, 1'b0);
      expectAll("stop.req", 2'b00, 2'b00, 2'b01, 0, 0);
      idle("stop.c8", 2'b00, 2'b00, 2'b01, 0, 0);
      idle("stop.c9", 2'b01, 2'b01, 2'b01, 0, 0);
      idle("stop.c10", 2'b00, 2'b01, 2'b01, 0, 0);
      idle("stop.c11", 2'b00, 2'b01, 2'b01, 0, 0);
      idle("stop.c12", 2'b01, 2'b00, 2'b00, 1, 0);
      idle("stop.c13", 2'b00, 2'b00, 2'b00, 1, 0);

      // div=0 clamps to 1 and flags, bad channel is ignored but flags, error is sticky
      applyStimulus(1'b0, 1'b1, 3'd1, 32'd0, 1'b1);
      expectAll("err.div0", 2'b00, 2'b00, 2'b10, 1, 1);
      idle("err.c1", 2'b10, 2'b10, 2'b10, 1, 1);
      idle("err.c2", 2'b10, 2'b00, 2'b10, 1, 1);
      applyStimulus(1'b0, 1'b1, 3'd5, 32'd7, 1'b1);
      expectAll("err.ch5", 2'b10, 2'b10, 2'b10, 1, 1);
      idle("err.c4", 2'b10, 2'b00, 2'b10, 1, 1);
      applyStimulus(1'b1, 1'b0, 3'd0, 32'd0, 1'b0);
      expectAll("err.rst", 2'b00, 2'b00, 2'b00, 0, 0);
      idle("err.c6", 2'b00, 2'b00, 2'b00, 1, 0);
      applyStimulus(1'b0, 1'b1, 3'd5, 32'd7, 1'b1);
      expectAll("err.ch5only", 2'b00, 2'b00, 2'b00, 1, 1);
      idle("err.c8", 2'b00, 2'b00, 2'b00, 1, 1);
      applyStimulus(1'b1, 1'b0, 3'd0, 32'd0, 1'b0);
      expectAll("err.rst2", 2'b00, 2'b00, 2'b00, 0, 0);
      idle("err.c10", 2'b00, 2'b00, 2'b00, 1, 0);

      // config landing on a terminal count waits for the next one; reset then drops a PEND
      applyStimulus(1'b0, 1'b1, 3'd0, 32'd2, 1'b1);
      expectAll("tc.acc", 2'b00, 2'b00, 2'b01, 1, 0);
      idle("tc.c1", 2'b00, 2'b00, 2'b01, 1, 0);
      applyStimulus(1'b0, 1'b1, 3'd0, 32'd3, 1'b1);
      expectAll("tc.collide", 2'b01, 2'b01, 2'b01, 0, 0);
      idle("tc.c3", 2'b00, 2'b01, 2'b01, 0, 0);
      idle("tc.c4", 2'b01, 2'b00, 2'b01, 1, 0);
      idle("tc.c5", 2'b00, 2'b00, 2'b01, 1, 0);
      idle("tc.c6", 2'b00, 2'b00, 2'b01, 1, 0);
      idle("tc.c7", 2'b01, 2'b01, 2'b01, 1, 0);
      applyStimulus(1'b0, 1'b1, 3'd0, 32'd5, 1'b1);
      expectAll("rp.pend", 2'b00, 2'b01, 2'b01, 0, 0);
      applyStimulus(1'b1, 1'b0, 3'd0, 32'd0, 1'b0);
      expectAll("rp.rst", 2'b00, 2'b00, 2'b00, 0, 0);
      for (int i = 0; i < 5; i++) begin
         idle($sformatf("rp.after%0d", i), 2'b00, 2'b00, 2'b00, 1, 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
